// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that feeds a UART transmitter one frame at a time.
// Optional sticky overflow flag is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr,
    input  logic [DBIT-1:0] w_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] level,
    output logic            busy,
    output logic            overflow,
    input  logic            ovf_clr,
    output logic            tx_start,
    output logic [7:0]      tx_din,
    input  logic            tx_done_tick
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEVEL_FULL = DEPTH[ADDR_W:0];
    localparam logic [0:0]      IDLE       = 1'b0;
    localparam logic [0:0]      WAIT       = 1'b1;

    logic [DBIT-1:0]   mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [0:0]        state;
    logic [7:0]        rd_byte;
    logic              push;
    logic              pop;

    // Launch handshake: tx_start is a one-cycle request carrying tx_din; the
    // transmitter owns that byte until it answers with a one-cycle tx_done_tick,
    // and no further tx_start is issued before then (state WAIT == busy).
    assign busy  = (state == WAIT);
    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);
    assign push  = wr && !full;
    assign pop   = (state == IDLE) && !empty;

    always_comb begin
        rd_byte = '0;
        rd_byte[DBIT-1:0] = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            tx_start <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                tx_din   <= rd_byte;
                tx_start <= 1'b1;
            end
            // Simultaneous push and pop leave the count unchanged.
            if (push && !pop) begin
                level <= level + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                level <= level - (ADDR_W+1)'(1);
            end
            if (state == IDLE) begin
                if (pop) begin
                    state <= WAIT;
                end
            end else if (tx_done_tick) begin
                state <= IDLE;
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // A dropped write in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard on launched bytes plus a
// transmitter model that answers each tx_start with tx_done_tick 20 cycles later.
module tb_uart_tx_fifo;
  localparam int DBIT     = 8;
  localparam int ADDR_W   = 4;
  localparam int DONE_DLY = 20;
`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic            clk;
  logic            reset_n;
  logic            wr;
  logic [DBIT-1:0] w_data;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] level;
  logic            busy;
  logic            overflow;
  logic            ovf_clr;
  logic            tx_start;
  logic [7:0]      tx_din;
  logic            tx_done_tick;

  uart_tx_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr           (wr),
    .w_data       (w_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .busy         (busy),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [7:0] exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_start  = 0;
  int   n_done   = 0;
  int   done_cyc = 0;
  int   seen_done = 0;
  int   gap_base = 0;
  bit   gap_chk  = 1'b0;
  bit   tx_hold  = 1'b0;
  bit   full_seen = 1'b0;
  int   tx_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // transmitter model
  initial begin : xmtr
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_tick = 1'b0;
      if (!reset_n) begin
        tx_cnt = 0;
      end else if (tx_start) begin
        tx_cnt = DONE_DLY;
      end else if (tx_cnt > 0 && !tx_hold) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done_tick = 1'b1;
          done_cyc = cyc;
          n_done++;
        end
      end
    end
  end

  // output monitor: every launch pops the next expected byte
  initial begin : monitor
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n_start++;
        if (exp_q.size() == 0) begin
          check("start_unexpected", 32'(1), 32'(0));
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_din", 32'(tx_din), 32'(exp_b));
        end
        if (gap_chk && n_done != seen_done && n_done > gap_base) begin
          check("start_gap", 32'(cyc - done_cyc), 32'(2));
        end
        seen_done = n_done;
      end
    end
  end

  // driver tasks (main thread stays aligned 1 time unit after a rising edge)
  task automatic next();
    @(negedge clk);
    if (full) full_seen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr     = 1'b1;
    w_data = b;
    if (!full) exp_q.push_back(b);
    next();
    wr = 1'b0;
  endtask

  task automatic drain(input int limit, input string tag);
    int t;
    t = 0;
    while (!(empty && !busy) && t < limit) begin
      next();
      t++;
    end
    check({tag, "_drained"}, 32'(t < limit), 32'(1));
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin : main
    int d0;
    int k;
    int tgt;
    int base;
    reset_n = 1'b0;
    wr      = 1'b0;
    w_data  = '0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level", 32'(level), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_start", 32'(tx_start), 32'(0));
    check("rst_din", 32'(tx_din), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    next();

    // single byte, transmitter held so busy must persist
    tx_hold = 1'b1;
    push(8'hA5);
    @(negedge clk);
    check("t1_level1", 32'(level), 32'(1));
    check("t1_empty0", 32'(empty), 32'(0));
    check("t1_start_early", 32'(tx_start), 32'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_start", 32'(tx_start), 32'(1));
    check("t1_din", 32'(tx_din), 32'(8'hA5));
    check("t1_empty1", 32'(empty), 32'(1));
    check("t1_level0", 32'(level), 32'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_start_one_cycle", 32'(tx_start), 32'(0));
    @(posedge clk);
    #1;
    repeat (10) next();
    check("t1_busy_held", 32'(busy), 32'(1));
    check("t1_din_held", 32'(tx_din), 32'(8'hA5));
    tx_hold = 1'b0;
    drain(100, "t1");
    check("t1_busy_clear", 32'(busy), 32'(0));

    // burst of 16 with free-running transmitter
    full_seen = 1'b0;
    gap_base  = n_done;
    gap_chk   = 1'b1;
    base      = n_start;
    for (int i = 0; i < 16; i++) push(8'(i));
    drain(1000, "t2");
    gap_chk = 1'b0;
    check("t2_starts", 32'(n_start - base), 32'(16));
    check("t2_never_full", 32'(full_seen), 32'(0));

    // overfill with the transmitter stalled
    tx_hold = 1'b1;
    for (int i = 0; i < 18; i++) push(8'(8'h40 + i));
    check("t3_level16", 32'(level), 32'(16));
    check("t3_full", 32'(full), 32'(1));
    check("t3_busy", 32'(busy), 32'(1));
    check("t3_ovf_set", 32'(overflow), 32'(OVF_EXP));
    ovf_clr = 1'b1;
    next();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'(0));
    ovf_clr = 1'b1;
    push(8'hEE);
    ovf_clr = 1'b0;
    check("t3_set_beats_clr", 32'(overflow), 32'(OVF_EXP));
    ovf_clr = 1'b1;
    next();
    ovf_clr = 1'b0;
    check("t3_ovf_clr2", 32'(overflow), 32'(0));
    tx_hold = 1'b0;
    drain(2000, "t3");

    // wrap-around: random data, completions at levels 3..8
    tx_hold = 1'b1;
    k = 0;
    while (k < 40) begin
      tgt = int'($urandom_range(3, 8));
      while (int'(level) < tgt && k < 40) begin
        push(8'($urandom_range(0, 255)));
        k++;
      end
      tx_hold = 1'b0;
      d0 = n_done;
      for (int t = 0; t < 100 && n_done == d0; t++) next();
      tx_hold = 1'b1;
      check("t4_done_seen", 32'(n_done != d0), 32'(1));
    end
    tx_hold = 1'b0;
    drain(3000, "t4");

    // simultaneous push and pop at level 5
    tx_hold = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    check("t5_pre_level", 32'(level), 32'(5));
    tx_hold = 1'b0;
    d0 = n_done;
    for (int t = 0; t < 100 && n_done == d0; t++) next();
    tx_hold = 1'b1;
    check("t5_idle", 32'(busy), 32'(0));
    push(8'h77);
    check("t5_level_same", 32'(level), 32'(5));
    check("t5_popped", 32'(tx_start), 32'(1));
    check("t5_busy", 32'(busy), 32'(1));

    // reset mid-stream with level 7 and a byte in flight
    push(8'h78);
    push(8'h79);
    check("t6_pre_level", 32'(level), 32'(7));
    check("t6_pre_busy", 32'(busy), 32'(1));
    reset_n = 1'b0;
    #1;
    check("t6_level", 32'(level), 32'(0));
    check("t6_empty", 32'(empty), 32'(1));
    check("t6_full", 32'(full), 32'(0));
    check("t6_busy", 32'(busy), 32'(0));
    check("t6_start", 32'(tx_start), 32'(0));
    check("t6_din", 32'(tx_din), 32'(0));
    check("t6_ovf", 32'(overflow), 32'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    next();
    reset_n = 1'b1;
    tx_hold = 1'b0;
    base = n_start;
    repeat (30) next();
    check("t6_no_start", 32'(n_start - base), 32'(0));
    push(8'h3C);
    drain(100, "t6");
    check("t6_restart", 32'(n_start - base), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
